vga_timing_gen: RTL and testbench

Raster timing generator that drives the VGA connector and feeds the pixel renderer. Divides the system clock to the pixel rate and runs horizontal and vertical counters. Publishes coord_x, coord_y and active_area to the renderer, takes the renderer's 12-bit rgb back, and drives hsync, vsync and blanked 4:4:4 colour to the pins. Default timing is 640x480 at 60 Hz from a 100 MHz clk.

---
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster bus between vga_timing_gen (master), the pixel renderer and the VGA pins.
// master drives timing, coordinates and pin outputs; slave supplies renderer colour.
interface vga_timing_gen_if;
    logic        pixel_tick;
    logic [9:0]  coord_x;
    logic [9:0]  coord_y;
    logic        active_area;
    logic        line_start;
    logic        frame_start;
    logic [11:0] rgb_in;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    modport master (
        output pixel_tick, coord_x, coord_y, active_area, line_start, frame_start,
        output hsync, vsync, vga_r, vga_g, vga_b,
        input  rgb_in
    );

    modport slave (
        input  pixel_tick, coord_x, coord_y, active_area, line_start, frame_start,
        input  hsync, vsync, vga_r, vga_g, vga_b,
        output rgb_in
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, registered sync/blank decode.
// Optional macro VGA_RGB_REG_EN registers colour and syncs one pixel period behind coord.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync pulse ending exactly at a 1024 total still compares correctly
    localparam logic [10:0]      H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0]      HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]      HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0]      V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0]      VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0]      VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             HS_ON    = 1'(HS_POL);
    localparam logic             HS_OFF   = ~HS_ON;
    localparam logic             VS_ON    = 1'(VS_POL);
    localparam logic             VS_OFF   = ~VS_ON;

    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic             r_active;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_line_start;
    logic             r_frame_start;

    logic [DIV_W-1:0] w_div_nxt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [9:0]       w_h_nxt;
    logic [9:0]       w_v_nxt;
    logic             w_active_nxt;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic [11:0]      w_rgb_blank;

    // Next-state values for divider and counters plus decode of the coordinate they lead to
    always_comb begin
        w_div_nxt = (r_div == DIV_LAST) ? {DIV_W{1'b0}} : r_div + DIV_W'(1);
        w_h_wrap  = (r_h == H_LAST);
        w_v_wrap  = (r_v == V_LAST);
        w_h_nxt   = w_h_wrap ? 10'd0 : r_h + 10'd1;
        if (w_h_wrap) begin
            w_v_nxt = w_v_wrap ? 10'd0 : r_v + 10'd1;
        end else begin
            w_v_nxt = r_v;
        end
        w_active_nxt = ({1'b0, w_h_nxt} < H_ACT) && ({1'b0, w_v_nxt} < V_ACT);
        w_hsync_nxt  = (({1'b0, w_h_nxt} >= HS_BEG) && ({1'b0, w_h_nxt} < HS_END)) ? HS_ON : HS_OFF;
        w_vsync_nxt  = (({1'b0, w_v_nxt} >= VS_BEG) && ({1'b0, w_v_nxt} < VS_END)) ? VS_ON : VS_OFF;
        w_rgb_blank  = r_active ? vga.rgb_in : 12'h000;
    end

    // Divider, counters and decoded strobes; decode is loaded with the counters so all stay coherent
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div         <= {DIV_W{1'b0}};
            r_tick        <= 1'b0;
            r_h           <= 10'd0;
            r_v           <= 10'd0;
            r_active      <= 1'b1;
            r_hsync       <= HS_OFF;
            r_vsync       <= VS_OFF;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_nxt;
            r_tick        <= (w_div_nxt == DIV_LAST);
            r_line_start  <= r_tick && w_h_wrap;
            r_frame_start <= r_tick && w_h_wrap && w_v_wrap;
            if (r_tick) begin
                r_h      <= w_h_nxt;
                r_v      <= w_v_nxt;
                r_active <= w_active_nxt;
                r_hsync  <= w_hsync_nxt;
                r_vsync  <= w_vsync_nxt;
            end
        end
    end

    assign vga.pixel_tick  = r_tick;
    assign vga.coord_x     = r_h;
    assign vga.coord_y     = r_v;
    assign vga.active_area = r_active;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;

`ifdef VGA_RGB_REG_EN
    logic [11:0] r_rgb_pin;
    logic        r_hsync_pin;
    logic        r_vsync_pin;

    // Pin stage: captures the finished pixel on each tick so colour and syncs lag coord together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb_pin   <= 12'h000;
            r_hsync_pin <= HS_OFF;
            r_vsync_pin <= VS_OFF;
        end else if (r_tick) begin
            r_rgb_pin   <= w_rgb_blank;
            r_hsync_pin <= r_hsync;
            r_vsync_pin <= r_vsync;
        end
    end

    assign vga.vga_r = r_rgb_pin[11:8];
    assign vga.vga_g = r_rgb_pin[7:4];
    assign vga.vga_b = r_rgb_pin[3:0];
    assign vga.hsync = r_hsync_pin;
    assign vga.vsync = r_vsync_pin;
`else
    assign vga.vga_r = w_rgb_blank[11:8];
    assign vga.vga_g = w_rgb_blank[7:4];
    assign vga.vga_b = w_rgb_blank[3:0];
    assign vga.hsync = r_hsync;
    assign vga.vsync = r_vsync;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster (24x14 totals, CLK_DIV=2).
// A scoreboard derives every cycle's outputs from the clock count since reset.
module tb_vga_timing_gen;
    localparam int D   = 2;
    localparam int HA  = 16;
    localparam int HF  = 2;
    localparam int HS  = 3;
    localparam int HB  = 3;
    localparam int VA  = 8;
    localparam int VF  = 2;
    localparam int VS  = 2;
    localparam int VB  = 2;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int HSP = 0;
    localparam int VSP = 0;
`ifdef VGA_RGB_REG_EN
    localparam int OFS = 1;
`else
    localparam int OFS = 0;
`endif

    typedef struct packed {
        logic        tick;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act;
        logic        ls;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] col;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    vga_timing_gen_if vif();

    vga_timing_gen #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .HS_POL(HSP), .VS_POL(VSP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vga(vif)
    );

    always #5 clk = ~clk;

    exp_t sb_q[$];
    exp_t prev_raw;
    exp_t mon_e;
    exp_t mon_got;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_clk = 0;
`ifdef VGA_RGB_REG_EN
    logic [11:0] pipe_col;
    logic        pipe_hs;
    logic        pipe_vs;
`endif

    // Reference: position follows directly from clocks elapsed since reset release
    function automatic exp_t model(input int n, input bit in_rst);
        exp_t e;
        int div, t, p, h, v;
        div = in_rst ? 0 : n % D;
        t   = in_rst ? 0 : n / D;
        p   = t % (HT * VT);
        h   = p % HT;
        v   = p / HT;
        e.tick = !in_rst && (div == D - 1);
        e.x    = 10'(h);
        e.y    = 10'(v);
        e.act  = (h < HA) && (v < VA);
        e.ls   = !in_rst && (div == 0) && (n >= D) && (h == 0);
        e.fs   = e.ls && (v == 0);
        e.hs   = (h >= HA + HF && h < HA + HF + HS) ? 1'(HSP) : ~1'(HSP);
        e.vs   = (v >= VA + VF && v < VA + VF + VS) ? 1'(VSP) : ~1'(VSP);
        e.col  = 12'h000;
        return e;
    endfunction

    task automatic clk_step(input logic rst, input logic [11:0] rgb);
        exp_t raw;
        exp_t e;
        reset      = rst;
        vif.rgb_in = rgb;
        @(posedge clk);
        if (rst) n_clk = 0;
        else     n_clk++;
        raw = model(n_clk, rst);
        e   = raw;
`ifdef VGA_RGB_REG_EN
        if (rst) begin
            pipe_col = 12'h000;
            pipe_hs  = ~1'(HSP);
            pipe_vs  = ~1'(VSP);
        end else if (prev_raw.tick) begin
            pipe_col = prev_raw.act ? rgb : 12'h000;
            pipe_hs  = prev_raw.hs;
            pipe_vs  = prev_raw.vs;
        end
        e.col = pipe_col;
        e.hs  = pipe_hs;
        e.vs  = pipe_vs;
`else
        e.col = raw.act ? rgb : 12'h000;
`endif
        prev_raw = raw;
        sb_q.push_back(e);
        #6;
    endtask

    task automatic run_until(input int x, input int y, input logic [11:0] rgb, output bit found);
        int k;
        k = 0;
        while (!(vif.coord_x == 10'(x) && vif.coord_y == 10'(y)) && k < 2 * HT * VT * D) begin
            clk_step(1'b0, rgb);
            k++;
        end
        found = (vif.coord_x == 10'(x) && vif.coord_y == 10'(y));
    endtask

    // Scoreboard monitor: compare every output each cycle away from the active edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_got = {vif.pixel_tick, vif.coord_x, vif.coord_y, vif.active_area, vif.line_start,
                       vif.frame_start, vif.hsync, vif.vsync, vif.vga_r, vif.vga_g, vif.vga_b};
            n_checks++;
            if (mon_got !== mon_e) begin
                n_errors++;
                $display("FAIL sb_cycle t=%0t got %h exp %h (x=%0d y=%0d)", $time, mon_got, mon_e,
                         mon_e.x, mon_e.y);
            end
        end
    end

    task automatic test_reset();
        repeat (3) clk_step(1'b1, 12'h123);
        n_checks++; if (vif.coord_x !== 10'd0)   begin n_errors++; $display("FAIL rst_x got %0d exp 0", vif.coord_x); end
        n_checks++; if (vif.coord_y !== 10'd0)   begin n_errors++; $display("FAIL rst_y got %0d exp 0", vif.coord_y); end
        n_checks++; if (vif.active_area !== 1'b1) begin n_errors++; $display("FAIL rst_active got %b exp 1", vif.active_area); end
        n_checks++; if (vif.hsync !== 1'b1)       begin n_errors++; $display("FAIL rst_hsync got %b exp 1", vif.hsync); end
        n_checks++; if (vif.vsync !== 1'b1)       begin n_errors++; $display("FAIL rst_vsync got %b exp 1", vif.vsync); end
        n_checks++; if (vif.line_start !== 1'b0)  begin n_errors++; $display("FAIL rst_ls got %b exp 0", vif.line_start); end
        n_checks++; if (vif.frame_start !== 1'b0) begin n_errors++; $display("FAIL rst_fs got %b exp 0", vif.frame_start); end
        n_checks++; if (vif.pixel_tick !== 1'b0)  begin n_errors++; $display("FAIL rst_tick got %b exp 0", vif.pixel_tick); end
    endtask

    task automatic test_tick_counters();
        int first_tick;
        int n_ticks;
        first_tick = -1;
        n_ticks = 0;
        for (int i = 1; i <= 4 * D; i++) begin
            clk_step(1'b0, 12'h5A5);
            if (vif.pixel_tick === 1'b1) begin
                n_ticks++;
                if (first_tick < 0) first_tick = i;
            end
            if (i == D) begin
                n_checks++; if (vif.coord_x !== 10'd1) begin n_errors++; $display("FAIL tick_x1 got %0d exp 1", vif.coord_x); end
            end
            if (i == 2 * D) begin
                n_checks++; if (vif.coord_x !== 10'd2) begin n_errors++; $display("FAIL tick_x2 got %0d exp 2", vif.coord_x); end
            end
        end
        n_checks++; if (first_tick !== D - 1) begin n_errors++; $display("FAIL tick_first got %0d exp %0d", first_tick, D - 1); end
        n_checks++; if (n_ticks !== 4)        begin n_errors++; $display("FAIL tick_count got %0d exp 4", n_ticks); end
        n_checks++; if (vif.coord_y !== 10'd0) begin n_errors++; $display("FAIL tick_y got %0d exp 0", vif.coord_y); end
    endtask

    task automatic test_line();
        int k, period, hs_low, bad;
        k = 0;
        while (vif.line_start !== 1'b1 && k < 4 * HT * D) begin clk_step(1'b0, 12'h0F0); k++; end
        n_checks++; if (vif.line_start !== 1'b1) begin n_errors++; $display("FAIL line_wait got timeout exp line_start"); end
        period = 0; hs_low = 0; bad = 0;
        do begin
            clk_step(1'b0, 12'h0F0);
            period++;
            if (vif.hsync === 1'(HSP)) begin
                hs_low++;
                if (vif.coord_x < 10'(HA + HF + OFS) || vif.coord_x >= 10'(HA + HF + HS + OFS)) bad++;
            end
        end while (vif.line_start !== 1'b1 && period < 2 * HT * D);
        n_checks++; if (period !== HT * D)  begin n_errors++; $display("FAIL line_period got %0d exp %0d", period, HT * D); end
        n_checks++; if (hs_low !== HS * D)  begin n_errors++; $display("FAIL hsync_width got %0d exp %0d", hs_low, HS * D); end
        n_checks++; if (bad !== 0)          begin n_errors++; $display("FAIL hsync_range got %0d exp 0", bad); end
    endtask

    task automatic test_frame();
        int k, period, lines, vs_low;
        k = 0;
        while (vif.frame_start !== 1'b1 && k < 2 * HT * VT * D) begin clk_step(1'b0, 12'h00F); k++; end
        n_checks++; if (vif.frame_start !== 1'b1) begin n_errors++; $display("FAIL frame_wait got timeout exp frame_start"); end
        n_checks++; if (vif.line_start !== 1'b1)  begin n_errors++; $display("FAIL frame_ls got %b exp 1", vif.line_start); end
        period = 0; lines = 0; vs_low = 0;
        do begin
            clk_step(1'b0, 12'h00F);
            period++;
            if (vif.line_start === 1'b1) lines++;
            if (vif.vsync === 1'(VSP)) vs_low++;
        end while (vif.frame_start !== 1'b1 && period < 2 * HT * VT * D);
        n_checks++; if (period !== HT * VT * D) begin n_errors++; $display("FAIL frame_period got %0d exp %0d", period, HT * VT * D); end
        n_checks++; if (lines !== VT)           begin n_errors++; $display("FAIL frame_lines got %0d exp %0d", lines, VT); end
        n_checks++; if (vs_low !== VS * HT * D) begin n_errors++; $display("FAIL vsync_width got %0d exp %0d", vs_low, VS * HT * D); end
    endtask

`ifndef VGA_RGB_REG_EN
    task automatic test_colour();
        bit found;
        run_until(HA - 1, 2, 12'hABC, found);
        n_checks++; if (!found) begin n_errors++; $display("FAIL col_find1 got timeout exp coord"); end
        n_checks++; if ({vif.vga_r, vif.vga_g, vif.vga_b} !== 12'hABC) begin n_errors++; $display("FAIL col_last_active got %h exp abc", {vif.vga_r, vif.vga_g, vif.vga_b}); end
        run_until(HA, 2, 12'hABC, found);
        n_checks++; if (!found || vif.active_area !== 1'b0) begin n_errors++; $display("FAIL col_first_blank_act got %b exp 0", vif.active_area); end
        n_checks++; if ({vif.vga_r, vif.vga_g, vif.vga_b} !== 12'h000) begin n_errors++; $display("FAIL col_hporch got %h exp 000", {vif.vga_r, vif.vga_g, vif.vga_b}); end
        run_until(0, VA, 12'hABC, found);
        n_checks++; if (!found || {vif.vga_r, vif.vga_g, vif.vga_b} !== 12'h000) begin n_errors++; $display("FAIL col_vporch got %h exp 000", {vif.vga_r, vif.vga_g, vif.vga_b}); end
        run_until(HA + HF + 1, VA + VF + 1, 12'hABC, found);
        n_checks++; if (!found || {vif.vga_r, vif.vga_g, vif.vga_b} !== 12'h000) begin n_errors++; $display("FAIL col_sync got %h exp 000", {vif.vga_r, vif.vga_g, vif.vga_b}); end
        n_checks++; if ({vif.hsync, vif.vsync} !== 2'b00) begin n_errors++; $display("FAIL col_sync_pins got %b exp 00", {vif.hsync, vif.vsync}); end
    endtask
`else
    task automatic test_reg_feature();
        bit found;
        run_until(HT - 1, VT - 1, 12'hF00, found);
        run_until(0, 0, 12'hF00, found);
        n_checks++; if (!found || vif.active_area !== 1'b1) begin n_errors++; $display("FAIL reg_act_rise got %b exp 1", vif.active_area); end
        n_checks++; if (vif.vga_r !== 4'h0) begin n_errors++; $display("FAIL reg_r_lag got %h exp 0", vif.vga_r); end
        run_until(1, 0, 12'hF00, found);
        n_checks++; if (!found || vif.vga_r !== 4'hF) begin n_errors++; $display("FAIL reg_r_on got %h exp f", vif.vga_r); end
        run_until(HA + HF, 0, 12'hF00, found);
        n_checks++; if (!found || vif.hsync !== 1'b1) begin n_errors++; $display("FAIL reg_hs_hold got %b exp 1", vif.hsync); end
        run_until(HA + HF + 1, 0, 12'hF00, found);
        n_checks++; if (!found || vif.hsync !== 1'b0) begin n_errors++; $display("FAIL reg_hs_fall got %b exp 0", vif.hsync); end
    endtask
`endif

    task automatic test_reset_midframe();
        bit found;
        bit fs_seen;
        int first_tick;
        run_until(12, 5, 12'h777, found);
        n_checks++; if (!found) begin n_errors++; $display("FAIL mid_find got timeout exp coord"); end
        clk_step(1'b1, 12'h777);
        n_checks++; if ({vif.coord_x, vif.coord_y} !== 20'd0) begin n_errors++; $display("FAIL mid_coord got %0d,%0d exp 0,0", vif.coord_x, vif.coord_y); end
        n_checks++; if ({vif.hsync, vif.vsync, vif.active_area} !== 3'b111) begin n_errors++; $display("FAIL mid_levels got %b exp 111", {vif.hsync, vif.vsync, vif.active_area}); end
        n_checks++; if ({vif.line_start, vif.frame_start} !== 2'b00) begin n_errors++; $display("FAIL mid_pulses got %b exp 00", {vif.line_start, vif.frame_start}); end
        fs_seen = 1'b0;
        first_tick = -1;
        for (int i = 1; i <= 2 * D; i++) begin
            clk_step(1'b0, 12'h777);
            if (vif.frame_start === 1'b1 || vif.line_start === 1'b1) fs_seen = 1'b1;
            if (vif.pixel_tick === 1'b1 && first_tick < 0) first_tick = i;
            if (i == D) begin
                n_checks++; if (vif.coord_x !== 10'd1) begin n_errors++; $display("FAIL mid_x1 got %0d exp 1", vif.coord_x); end
            end
        end
        n_checks++; if (fs_seen !== 1'b0)     begin n_errors++; $display("FAIL mid_no_pulse got %b exp 0", fs_seen); end
        n_checks++; if (first_tick !== D - 1) begin n_errors++; $display("FAIL mid_first_tick got %0d exp %0d", first_tick, D - 1); end
    endtask

    initial begin
        vif.rgb_in = 12'h000;
        prev_raw   = '0;
        test_reset();
        test_tick_counters();
        test_line();
        test_frame();
`ifndef VGA_RGB_REG_EN
        test_colour();
`else
        test_reg_feature();
`endif
        test_reset_midframe();
        repeat (2) clk_step(1'b0, 12'h000);
        n_checks++; if (sb_q.size() !== 0) begin n_errors++; $display("FAIL sb_drain got %0d exp 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
